// File: rtl/wash_cycle_ctrl_if.sv
// Signal bundle between the setup/display logic and the wash-cycle sequencer.
interface wash_cycle_ctrl_if;
  // Requests from setup and user controls
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  weight;
  logic [11:0] bal;
  logic        lid_open;
  logic        pause;
  logic        abort;
  logic        ack;
  // Status towards display and status LEDs
  logic [2:0]  phase;
  logic        busy;
  logic [7:0]  remain_s;
  logic [7:0]  fee;
  logic [11:0] bal_out;
  logic [1:0]  err_code;
  logic        done;
  logic        lock;
  logic        motor_on;

  modport master (
    output start, mode, weight, bal, lid_open, pause, abort, ack,
    input  phase, busy, remain_s, fee, bal_out, err_code, done, lock, motor_on
  );

  modport slave (
    input  start, mode, weight, bal, lid_open, pause, abort, ack,
    output phase, busy, remain_s, fee, bal_out, err_code, done, lock, motor_on
  );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine run sequencer: validates and charges a run, then steps the
// drum through wash/rinse/spin on a one-second tick with pause and lid interlock.
module wash_cycle_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input logic               clk,
  input logic               rst,
  wash_cycle_ctrl_if.slave  bus
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TickMax = CntW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWash  = 3'd1,
    StRinse = 3'd2,
    StSpin  = 3'd3,
    StPause = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  state_e          held_q, held_d;     // phase to return to from PAUSE
  logic [7:0]      remain_q, remain_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      fee_q, fee_d;
  logic [11:0]     bal_q, bal_d;
  logic [1:0]      err_q, err_d;
  logic [1:0]      mode_q, mode_d;     // mode of the run in progress
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            motor_q, motor_d;

  function automatic logic [7:0] wash_dur(input logic [1:0] m, input logic [4:0] w);
    logic [7:0] half;
    half = {4'b0, w[4:1]};
    case (m)
      2'd0:    wash_dur = 8'd5 + half;
      2'd1:    wash_dur = 8'd10 + half;
      2'd2:    wash_dur = 8'd15 + half;
      default: wash_dur = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] rinse_dur(input logic [1:0] m);
    case (m)
      2'd0:    rinse_dur = 8'd3;
      2'd1:    rinse_dur = 8'd6;
      2'd2:    rinse_dur = 8'd9;
      default: rinse_dur = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] spin_dur(input logic [1:0] m);
    case (m)
      2'd0:    spin_dur = 8'd2;
      2'd1:    spin_dur = 8'd4;
      default: spin_dur = 8'd6;
    endcase
  endfunction

  function automatic logic [7:0] unit_price(input logic [1:0] m);
    case (m)
      2'd0:    unit_price = 8'd2;
      2'd1:    unit_price = 8'd3;
      2'd2:    unit_price = 8'd4;
      default: unit_price = 8'd1;
    endcase
  endfunction

  logic [7:0] fee_calc;
  logic [7:0] wash_len;
  logic       running;
  logic       tick;
  logic       weight_bad;
  logic       bal_short;

  // Start-time evaluation of the requested run
  always_comb begin
    fee_calc   = unit_price(bus.mode) * {3'b0, bus.weight};
    wash_len   = wash_dur(bus.mode, bus.weight);
    weight_bad = (bus.weight == 5'd0) || (bus.weight > 5'd20);
    bal_short  = $signed(bus.bal) < $signed({4'b0, fee_calc});
    running    = (state_q == StWash) || (state_q == StRinse) || (state_q == StSpin);
    tick       = running && (cnt_q == TickMax);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      held_q   <= StIdle;
      remain_q <= '0;
      cnt_q    <= '0;
      fee_q    <= '0;
      bal_q    <= '0;
      err_q    <= '0;
      mode_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      motor_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      fee_q    <= fee_d;
      bal_q    <= bal_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      motor_q  <= motor_d;
    end
  end

  // Next-state: start checks, phase sequencing, pause/lid/abort handling
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    fee_d    = fee_q;
    bal_d    = bal_q;
    err_d    = err_q;
    mode_d   = mode_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.lid_open) begin
            state_d = StErr;
            err_d   = 2'd2;
          end else if (weight_bad) begin
            state_d = StErr;
            err_d   = 2'd3;
          end else if (bal_short) begin
            state_d = StErr;
            err_d   = 2'd1;
          end else begin
            fee_d  = fee_calc;
            bal_d  = bus.bal - {4'b0, fee_calc};
            err_d  = 2'd0;
            mode_d = bus.mode;
            cnt_d  = '0;
            // Zero-length phases are skipped; spin is never zero.
            if (wash_len != 8'd0) begin
              state_d  = StWash;
              remain_d = wash_len;
            end else if (rinse_dur(bus.mode) != 8'd0) begin
              state_d  = StRinse;
              remain_d = rinse_dur(bus.mode);
            end else begin
              state_d  = StSpin;
              remain_d = spin_dur(bus.mode);
            end
          end
        end
      end

      StWash, StRinse, StSpin: begin
        if (bus.abort) begin
          state_d  = StIdle;
          remain_d = '0;
          cnt_d    = '0;
        end else if (bus.lid_open || bus.pause) begin
          state_d = StPause;
          held_d  = state_q;
          // A tick coinciding with pause is discarded; the second restarts.
          if (tick) cnt_d = '0;
        end else if (tick) begin
          cnt_d = '0;
          if (remain_q > 8'd1) begin
            remain_d = remain_q - 8'd1;
          end else begin
            case (state_q)
              StWash: begin
                if (rinse_dur(mode_q) != 8'd0) begin
                  state_d  = StRinse;
                  remain_d = rinse_dur(mode_q);
                end else begin
                  state_d  = StSpin;
                  remain_d = spin_dur(mode_q);
                end
              end
              StRinse: begin
                state_d  = StSpin;
                remain_d = spin_dur(mode_q);
              end
              default: begin
                state_d  = StDone;
                remain_d = '0;
              end
            endcase
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StPause: begin
        if (bus.abort) begin
          state_d  = StIdle;
          remain_d = '0;
          cnt_d    = '0;
        end else if (bus.pause && !bus.lid_open) begin
          state_d = held_q;
        end
      end

      StDone, StErr: begin
        if (bus.ack) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // Status flags decoded from the next state so they register alongside it
  always_comb begin
    busy_d  = (state_d == StWash) || (state_d == StRinse) ||
              (state_d == StSpin) || (state_d == StPause);
    motor_d = (state_d == StWash) || (state_d == StRinse) || (state_d == StSpin);
    done_d  = (state_d == StDone);
  end

  assign bus.phase    = state_q;
  assign bus.busy     = busy_q;
  assign bus.remain_s = remain_q;
  assign bus.fee      = fee_q;
  assign bus.bal_out  = bal_q;
  assign bus.err_code = err_q;
  assign bus.done     = done_q;
  assign bus.lock     = busy_q;
  assign bus.motor_on = motor_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl with TICK_DIV = 4.
module tb_wash_cycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  wash_cycle_ctrl_if bus ();

  wash_cycle_ctrl #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [4:0] w, input logic [11:0] b);
    bus.mode   = m;
    bus.weight = w;
    bus.bal    = b;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic pulse_pause();
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 2'd0;
    bus.weight   = 5'd0;
    bus.bal      = 12'd0;
    bus.lid_open = 1'b0;
    bus.pause    = 1'b0;
    bus.abort    = 1'b0;
    bus.ack      = 1'b0;
    steps(2);

    // Reset state
    check("rst_phase", 32'(bus.phase), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_remain", 32'(bus.remain_s), 0);
    check("rst_fee", 32'(bus.fee), 0);
    check("rst_bal", 32'(bus.bal_out), 0);
    check("rst_err", 32'(bus.err_code), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_lock", 32'(bus.lock), 0);
    check("rst_motor", 32'(bus.motor_on), 0);
    rst = 1'b1;
    step();

    // Standard run: wash 13, rinse 6, spin 4
    do_start(2'd1, 5'd6, 12'd100);
    check("std_phase", 32'(bus.phase), 1);
    check("std_remain", 32'(bus.remain_s), 13);
    check("std_fee", 32'(bus.fee), 18);
    check("std_bal", 32'(bus.bal_out), 82);
    check("std_lock", 32'(bus.lock), 1);
    check("std_motor", 32'(bus.motor_on), 1);
    steps(51);
    check("std_wash_last", 32'(bus.remain_s), 1);
    check("std_wash_last_ph", 32'(bus.phase), 1);
    step();
    check("std_rinse_ph", 32'(bus.phase), 2);
    check("std_rinse_rem", 32'(bus.remain_s), 6);
    steps(24);
    check("std_spin_ph", 32'(bus.phase), 3);
    check("std_spin_rem", 32'(bus.remain_s), 4);
    steps(16);
    check("std_done_ph", 32'(bus.phase), 5);
    check("std_done", 32'(bus.done), 1);
    check("std_done_lock", 32'(bus.lock), 0);
    check("std_done_rem", 32'(bus.remain_s), 0);
    pulse_ack();
    check("std_ack_ph", 32'(bus.phase), 0);

    // Start rejects
    do_start(2'd2, 5'd5, 12'd10);
    check("rej_bal_ph", 32'(bus.phase), 6);
    check("rej_bal_err", 32'(bus.err_code), 1);
    check("rej_bal_fee", 32'(bus.fee), 18);
    check("rej_bal_balout", 32'(bus.bal_out), 82);
    check("rej_bal_busy", 32'(bus.busy), 0);
    pulse_ack();
    check("rej_ack_ph", 32'(bus.phase), 0);
    do_start(2'd0, 5'd0, 12'd100);
    check("rej_w0_err", 32'(bus.err_code), 3);
    pulse_ack();
    do_start(2'd0, 5'd21, 12'd100);
    check("rej_w21_err", 32'(bus.err_code), 3);
    pulse_ack();
    bus.lid_open = 1'b1;
    do_start(2'd0, 5'd0, 12'd100);
    check("rej_lid_err", 32'(bus.err_code), 2);
    bus.lid_open = 1'b0;
    pulse_ack();
    do_start(2'd0, 5'd1, 12'hFFB);
    check("rej_neg_err", 32'(bus.err_code), 1);
    check("rej_neg_ph", 32'(bus.phase), 6);
    pulse_ack();

    // Spin-only run
    do_start(2'd3, 5'd4, 12'd50);
    check("spin_ph", 32'(bus.phase), 3);
    check("spin_rem", 32'(bus.remain_s), 6);
    check("spin_fee", 32'(bus.fee), 4);
    check("spin_bal", 32'(bus.bal_out), 46);
    check("spin_err_clr", 32'(bus.err_code), 0);
    steps(23);
    check("spin_last_ph", 32'(bus.phase), 3);
    step();
    check("spin_done_ph", 32'(bus.phase), 5);
    pulse_ack();

    // Pause and lid interlock: quick mode, weight 4 -> wash 7
    do_start(2'd0, 5'd4, 12'd100);
    check("pz_ph", 32'(bus.phase), 1);
    check("pz_rem", 32'(bus.remain_s), 7);
    check("pz_bal", 32'(bus.bal_out), 92);
    steps(2);
    pulse_pause();
    check("pz_enter_ph", 32'(bus.phase), 4);
    check("pz_enter_motor", 32'(bus.motor_on), 0);
    check("pz_enter_lock", 32'(bus.lock), 1);
    steps(100);
    check("pz_hold_ph", 32'(bus.phase), 4);
    check("pz_hold_rem", 32'(bus.remain_s), 7);
    bus.lid_open = 1'b1;
    step();
    pulse_pause();
    check("pz_lid_ignored", 32'(bus.phase), 4);
    bus.lid_open = 1'b0;
    step();
    pulse_pause();
    check("pz_resume_ph", 32'(bus.phase), 1);
    check("pz_resume_rem", 32'(bus.remain_s), 7);
    // Counter was held at 2, so the second completes two cycles later
    step();
    check("pz_cnt_held", 32'(bus.remain_s), 7);
    step();
    check("pz_cnt_tick", 32'(bus.remain_s), 6);
    steps(24);
    check("pz_rinse_ph", 32'(bus.phase), 2);
    check("pz_rinse_rem", 32'(bus.remain_s), 3);
    step();
    bus.lid_open = 1'b1;
    step();
    check("lid_rinse_ph", 32'(bus.phase), 4);
    check("lid_rinse_rem", 32'(bus.remain_s), 3);
    check("lid_rinse_motor", 32'(bus.motor_on), 0);
    bus.lid_open = 1'b0;
    step();
    pulse_pause();
    check("lid_resume_ph", 32'(bus.phase), 2);

    // Tick and pause in the same cycle: counter sits at 3 after two edges
    steps(2);
    pulse_pause();
    check("tp_ph", 32'(bus.phase), 4);
    check("tp_rem", 32'(bus.remain_s), 3);
    pulse_pause();
    check("tp_resume_ph", 32'(bus.phase), 2);
    steps(3);
    check("tp_full_sec", 32'(bus.remain_s), 3);
    step();
    check("tp_tick", 32'(bus.remain_s), 2);

    // Abort wins over resume in PAUSE
    pulse_pause();
    check("ab_pause_ph", 32'(bus.phase), 4);
    bus.abort = 1'b1;
    bus.pause = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.pause = 1'b0;
    check("ab_ph", 32'(bus.phase), 0);
    check("ab_rem", 32'(bus.remain_s), 0);
    check("ab_bal", 32'(bus.bal_out), 92);
    check("ab_fee", 32'(bus.fee), 8);
    check("ab_lock", 32'(bus.lock), 0);

    // Reset mid-run during SPIN
    do_start(2'd3, 5'd4, 12'd50);
    steps(5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mrst_ph", 32'(bus.phase), 0);
    check("mrst_rem", 32'(bus.remain_s), 0);
    check("mrst_fee", 32'(bus.fee), 0);
    check("mrst_bal", 32'(bus.bal_out), 0);
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_motor", 32'(bus.motor_on), 0);
    do_start(2'd0, 5'd2, 12'd20);
    check("post_ph", 32'(bus.phase), 1);
    check("post_rem", 32'(bus.remain_s), 6);
    check("post_bal", 32'(bus.bal_out), 16);
    steps(24);
    check("post_rinse_ph", 32'(bus.phase), 2);
    check("post_rinse_rem", 32'(bus.remain_s), 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
